// File: rtl/adc_fir_fft_chain.sv
// Synthetic sine ADC -> 8-tap moving-average FIR -> streaming 8-point radix-2 FFT.
// Every stage is registered and brought out for observation.
module adc_fir_fft_chain #(
  parameter int unsigned ADC_STEP   = 1,
  parameter int unsigned ADC_PHASE0 = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic signed [15:0] adc_out,
  output logic signed [15:0] filtered_out,
  output logic signed [15:0] fft_real_out,
  output logic signed [15:0] fft_imag_out,
  output logic               fft_valid,
  output logic [2:0]         fft_index
);
  localparam logic [3:0] P_STEP   = 4'(ADC_STEP % 16);
  localparam logic [3:0] P_PHASE0 = 4'(ADC_PHASE0 % 16);

  logic [3:0]         r_phase;
  logic signed [15:0] r_taps [0:6];
  logic signed [15:0] r_buf  [0:6];
  logic signed [15:0] r_xre  [0:7];
  logic signed [15:0] r_xim  [0:7];
  logic [2:0]         r_widx;
  logic [2:0]         r_ridx;
  logic               r_loaded;

  logic signed [18:0] w_fir_sum;
  logic signed [15:0] w_x    [0:7];
  logic signed [19:0] w_s0re [0:7];
  logic signed [19:0] w_s0im [0:7];
  logic signed [19:0] w_s1re [0:7];
  logic signed [19:0] w_s1im [0:7];
  logic signed [19:0] w_s2re [0:7];
  logic signed [19:0] w_s2im [0:7];
  logic signed [19:0] w_s3re [0:7];
  logic signed [19:0] w_s3im [0:7];

  function automatic logic signed [15:0] lut(input logic [3:0] n);
    logic signed [15:0] v;
    case (n[2:0])
      3'd0:    v = 16'sd0;
      3'd1:    v = 16'sd3061;
      3'd2:    v = 16'sd5657;
      3'd3:    v = 16'sd7391;
      3'd4:    v = 16'sd8000;
      3'd5:    v = 16'sd7391;
      3'd6:    v = 16'sd5657;
      default: v = 16'sd3061;
    endcase
    return n[3] ? -v : v;
  endfunction

  function automatic logic [2:0] bitrev(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  // Q15 multiply by cos(pi/4), floored per component
  function automatic logic signed [19:0] mulc(input logic signed [19:0] a);
    logic signed [35:0] p;
    p = 36'(a) * 36'sd23170;
    return 20'(p >>> 15);
  endfunction

  function automatic logic signed [19:0] tw_re(input logic signed [19:0] br, input logic signed [19:0] bi,
                                               input logic [1:0] k);
    case (k)
      2'd0:    return br;
      2'd1:    return mulc(br) + mulc(bi);
      2'd2:    return bi;
      default: return mulc(bi) - mulc(br);
    endcase
  endfunction

  function automatic logic signed [19:0] tw_im(input logic signed [19:0] br, input logic signed [19:0] bi,
                                               input logic [1:0] k);
    case (k)
      2'd0:    return bi;
      2'd1:    return mulc(bi) - mulc(br);
      2'd2:    return -br;
      default: return -(mulc(br) + mulc(bi));
    endcase
  endfunction

  function automatic logic signed [19:0] bfly(input logic signed [19:0] a, input logic signed [19:0] t,
                                              input logic sub);
    return sub ? a - t : a + t;
  endfunction

  function automatic logic signed [15:0] sat(input logic signed [19:0] v);
    logic signed [19:0] q;
    q = v >>> 3;
    if (q > 20'sd32767)  return 16'sh7fff;
    if (q < -20'sd32768) return 16'sh8000;
    return q[15:0];
  endfunction

  always_comb begin
    w_fir_sum = 19'(adc_out);
    for (int unsigned i = 0; i < 7; i++) w_fir_sum = w_fir_sum + 19'(r_taps[3'(i)]);
  end

  // The newest sample joins the frame directly, so buf[7] is never stored
  always_comb begin
    for (int unsigned i = 0; i < 7; i++) w_x[3'(i)] = r_buf[3'(i)];
    w_x[7] = filtered_out;
  end

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      w_s0re[3'(i)] = 20'(w_x[bitrev(3'(i))]);
      w_s0im[3'(i)] = '0;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      w_s1re[3'(i)] = bfly(w_s0re[3'(i) & 3'b110],
                           tw_re(w_s0re[3'(i) | 3'b001], w_s0im[3'(i) | 3'b001], 2'd0), (i & 1) != 0);
      w_s1im[3'(i)] = bfly(w_s0im[3'(i) & 3'b110],
                           tw_im(w_s0re[3'(i) | 3'b001], w_s0im[3'(i) | 3'b001], 2'd0), (i & 1) != 0);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      w_s2re[3'(i)] = bfly(w_s1re[3'(i) & 3'b101],
                           tw_re(w_s1re[3'(i) | 3'b010], w_s1im[3'(i) | 3'b010], 2'((i & 1) << 1)),
                           (i & 2) != 0);
      w_s2im[3'(i)] = bfly(w_s1im[3'(i) & 3'b101],
                           tw_im(w_s1re[3'(i) | 3'b010], w_s1im[3'(i) | 3'b010], 2'((i & 1) << 1)),
                           (i & 2) != 0);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      w_s3re[3'(i)] = bfly(w_s2re[3'(i) & 3'b011],
                           tw_re(w_s2re[3'(i) | 3'b100], w_s2im[3'(i) | 3'b100], 2'(i & 3)), (i & 4) != 0);
      w_s3im[3'(i)] = bfly(w_s2im[3'(i) & 3'b011],
                           tw_im(w_s2re[3'(i) | 3'b100], w_s2im[3'(i) | 3'b100], 2'(i & 3)), (i & 4) != 0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase      <= P_PHASE0;
      adc_out      <= '0;
      filtered_out <= '0;
      fft_real_out <= '0;
      fft_imag_out <= '0;
      fft_valid    <= 1'b0;
      fft_index    <= '0;
      r_widx       <= '0;
      r_ridx       <= '0;
      r_loaded     <= 1'b0;
      for (int unsigned i = 0; i < 7; i++) begin
        r_taps[3'(i)] <= '0;
        r_buf[3'(i)]  <= '0;
      end
      for (int unsigned i = 0; i < 8; i++) begin
        r_xre[3'(i)] <= '0;
        r_xim[3'(i)] <= '0;
      end
    end else begin
      adc_out      <= lut(r_phase);
      r_phase      <= r_phase + P_STEP;
      r_taps[0]    <= adc_out;
      for (int unsigned i = 1; i < 7; i++) r_taps[3'(i)] <= r_taps[3'(i - 1)];
      filtered_out <= w_fir_sum[18:3];
      r_widx       <= r_widx + 3'd1;
      if (r_loaded) begin
        fft_real_out <= r_xre[r_ridx];
        fft_imag_out <= r_xim[r_ridx];
        fft_index    <= r_ridx;
        fft_valid    <= 1'b1;
      end
      // Bank load overrides the read-index increment; the old bin 7 still goes out this edge
      if (r_widx == 3'd7) begin
        for (int unsigned i = 0; i < 8; i++) begin
          r_xre[3'(i)] <= sat(w_s3re[3'(i)]);
          r_xim[3'(i)] <= sat(w_s3im[3'(i)]);
        end
        r_ridx   <= '0;
        r_loaded <= 1'b1;
      end else begin
        r_buf[r_widx] <= filtered_out;
        r_ridx        <= r_ridx + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_adc_fir_fft_chain.sv
// Four parameterisations of adc_fir_fft_chain against a cycle model with an FFT-bin scoreboard.
module tb_adc_fir_fft_chain;
  localparam int NI   = 4;
  localparam int NCYC = 320;

  typedef struct packed { int re; int im; int k; } bin_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic signed [15:0] d_adc  [NI];
  logic signed [15:0] d_filt [NI];
  logic signed [15:0] d_re   [NI];
  logic signed [15:0] d_im   [NI];
  logic               d_valid[NI];
  logic [2:0]         d_idx  [NI];

  int n_checks = 0;
  int n_fail   = 0;

  int LUTV [16] = '{0, 3061, 5657, 7391, 8000, 7391, 5657, 3061,
                    0, -3061, -5657, -7391, -8000, -7391, -5657, -3061};
  int STEP [NI] = '{1, 0, 2, 4};
  int PH0  [NI] = '{0, 4, 0, 4};

  int   m_phase [NI];
  int   m_adc   [NI];
  int   m_filt  [NI];
  int   m_taps  [NI][7];
  int   m_buf   [NI][7];
  int   m_w     [NI];
  bit   m_loaded[NI];
  int   m_valid [NI];
  int   m_ore   [NI];
  int   m_oim   [NI];
  int   m_oidx  [NI];
  bin_t sb      [NI][$];

  int f_x [8];
  int f_re[8];
  int f_im[8];
  int since_rel;
  int c_mag[8];

  always #5 clk = ~clk;

  adc_fir_fft_chain #(.ADC_STEP(1), .ADC_PHASE0(0)) u_def (
    .clk(clk), .reset(reset), .adc_out(d_adc[0]), .filtered_out(d_filt[0]),
    .fft_real_out(d_re[0]), .fft_imag_out(d_im[0]), .fft_valid(d_valid[0]), .fft_index(d_idx[0]));
  adc_fir_fft_chain #(.ADC_STEP(0), .ADC_PHASE0(4)) u_dc (
    .clk(clk), .reset(reset), .adc_out(d_adc[1]), .filtered_out(d_filt[1]),
    .fft_real_out(d_re[1]), .fft_imag_out(d_im[1]), .fft_valid(d_valid[1]), .fft_index(d_idx[1]));
  adc_fir_fft_chain #(.ADC_STEP(2), .ADC_PHASE0(0)) u_s2 (
    .clk(clk), .reset(reset), .adc_out(d_adc[2]), .filtered_out(d_filt[2]),
    .fft_real_out(d_re[2]), .fft_imag_out(d_im[2]), .fft_valid(d_valid[2]), .fft_index(d_idx[2]));
  adc_fir_fft_chain #(.ADC_STEP(4), .ADC_PHASE0(4)) u_s4 (
    .clk(clk), .reset(reset), .adc_out(d_adc[3]), .filtered_out(d_filt[3]),
    .fft_real_out(d_re[3]), .fft_imag_out(d_im[3]), .fft_valid(d_valid[3]), .fft_index(d_idx[3]));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int q15(input int a);
    longint p;
    p = longint'(a) * 64'sd23170;
    return int'(p >>> 15);
  endfunction

  function automatic int sat16(input int v);
    int q;
    q = v >>> 3;
    if (q > 32767)  return 32767;
    if (q < -32768) return -32768;
    return q;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // In-place iterative DIT on f_x, results into f_re/f_im
  task automatic fft_model();
    int re[8];
    int im[8];
    int a, b, k, tr, ti, mr, mi;
    for (int n = 0; n < 8; n++) begin
      re[n] = f_x[((n & 1) << 2) | (n & 2) | ((n >> 2) & 1)];
      im[n] = 0;
    end
    for (int h = 1; h < 8; h = h * 2) begin
      for (int base = 0; base < 8; base += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          a  = base + j;
          b  = a + h;
          k  = j * (4 / h);
          mr = q15(re[b]);
          mi = q15(im[b]);
          case (k)
            0:       begin tr = re[b];   ti = im[b];    end
            1:       begin tr = mr + mi; ti = mi - mr;  end
            2:       begin tr = im[b];   ti = -re[b];   end
            default: begin tr = mi - mr; ti = -mr - mi; end
          endcase
          re[b] = re[a] - tr;
          im[b] = im[a] - ti;
          re[a] = re[a] + tr;
          im[a] = im[a] + ti;
        end
      end
    end
    for (int n = 0; n < 8; n++) begin
      f_re[n] = sat16(re[n]);
      f_im[n] = sat16(im[n]);
    end
  endtask

  task automatic step_model(input int g, input bit rst);
    int nadc, sum;
    bin_t b;
    if (rst) begin
      m_phase[g]  = PH0[g];
      m_adc[g]    = 0;
      m_filt[g]   = 0;
      m_w[g]      = 0;
      m_loaded[g] = 1'b0;
      m_valid[g]  = 0;
      m_ore[g]    = 0;
      m_oim[g]    = 0;
      m_oidx[g]   = 0;
      for (int i = 0; i < 7; i++) begin
        m_taps[g][i] = 0;
        m_buf[g][i]  = 0;
      end
      sb[g].delete();
    end else begin
      nadc       = LUTV[m_phase[g]];
      m_phase[g] = (m_phase[g] + STEP[g]) % 16;
      sum        = m_adc[g];
      for (int i = 0; i < 7; i++) sum += m_taps[g][i];
      if (m_loaded[g]) begin
        if (sb[g].size() > 0) b = sb[g].pop_front();
        else begin b.re = 0; b.im = 0; b.k = -1; end
        m_valid[g] = 1;
        m_ore[g]   = b.re;
        m_oim[g]   = b.im;
        m_oidx[g]  = b.k;
      end
      if (m_w[g] == 7) begin
        for (int i = 0; i < 7; i++) f_x[i] = m_buf[g][i];
        f_x[7] = m_filt[g];
        fft_model();
        for (int k = 0; k < 8; k++) begin
          b.re = f_re[k]; b.im = f_im[k]; b.k = k;
          sb[g].push_back(b);
        end
        m_loaded[g] = 1'b1;
      end else begin
        m_buf[g][m_w[g]] = m_filt[g];
      end
      for (int i = 6; i > 0; i--) m_taps[g][i] = m_taps[g][i-1];
      m_taps[g][0] = m_adc[g];
      m_adc[g]     = nadc;
      m_filt[g]    = sum >>> 3;
      m_w[g]       = (m_w[g] + 1) % 8;
    end
  endtask

  initial begin
    int e, ok;
    since_rel = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (reset) since_rel = 0;
      else       since_rel++;
      for (int g = 0; g < NI; g++) begin
        step_model(g, reset);
        check($sformatf("adc[%0d]", g),   int'(d_adc[g]),   m_adc[g]);
        check($sformatf("filt[%0d]", g),  int'(d_filt[g]),  m_filt[g]);
        check($sformatf("valid[%0d]", g), int'(d_valid[g]), m_valid[g]);
        check($sformatf("re[%0d]", g),    int'(d_re[g]),    m_ore[g]);
        check($sformatf("im[%0d]", g),    int'(d_im[g]),    m_oim[g]);
        check($sformatf("idx[%0d]", g),   int'(d_idx[g]),   m_oidx[g]);
      end

      e = (since_rel >= 9) ? (since_rel - 9) % 8 : 0;
      if (since_rel == 0) begin
        check("rst_valid", int'(d_valid[0]), 0);
        check("rst_adc",   int'(d_adc[0]),   0);
        check("rst_re",    int'(d_re[0]),    0);
      end
      if (since_rel == 1) check("restart_adc0", int'(d_adc[0]), 0);
      if (since_rel == 2) check("restart_adc1", int'(d_adc[0]), 3061);
      if (since_rel == 3) check("restart_adc2", int'(d_adc[0]), 5657);
      if (since_rel == 9) check("fir_lut0_7", int'(d_filt[0]), 5027);
      if (since_rel >= 9) check("dc_filt", int'(d_filt[1]), 8000);
      if (since_rel >= 25) begin
        check("dc_re", int'(d_re[1]), (e == 0) ? 8000 : 0);
        check("dc_im", int'(d_im[1]), 0);
        check("s2_re", int'(d_re[2]), 0);
        check("s2_im", int'(d_im[2]), 0);
      end
      if (since_rel >= 10) check("s2_filt", int'(d_filt[2]), 0);
      if (since_rel >= 9)  check("s4_filt", int'(d_filt[3]), 0);
      if (!reset || since_rel == 0) check("s4_valid", int'(d_valid[3]), (since_rel >= 9) ? 1 : 0);
      if (since_rel >= 9) begin
        check("s4_idx", int'(d_idx[3]), e);
        c_mag[e] = iabs(int'(d_re[0])) + iabs(int'(d_im[0]));
        // Bin 7 is the conjugate mirror of bin 1 for real input, so it is left out
        if (e == 7 && since_rel >= 32) begin
          ok = 1;
          for (int k = 2; k < 7; k++) if (c_mag[k] >= c_mag[1]) ok = 0;
          check("bin1_dom", ok, 1);
        end
      end

      reset = (cyc < 1) || (cyc == 150) || (cyc == 151);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
